// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run_ctrl sequencer.
package run_ctrl_pkg;

  localparam int unsigned RUN_CTRL_MAX_CORES = 16;

  typedef enum logic [1:0] {
    StHold,
    StRun,
    StDone,
    StFault
  } run_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_ctrl_halt_tracker.sv
// Sticky per-core halt record, first-halt priority encoder and
// all-halted detection for run_ctrl.
module run_ctrl_halt_tracker
  import run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned ID_W      = id_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_clear,
  input  logic [NUM_CORES-1:0] i_halt,
  input  logic [NUM_CORES-1:0] i_mask,
  output logic [NUM_CORES-1:0] o_halted_vec,
  output logic [ID_W-1:0]      o_first_id,
  output logic                 o_all_next
);

  logic [NUM_CORES-1:0] r_vec;
  logic [NUM_CORES-1:0] w_new;
  logic [NUM_CORES-1:0] w_vec_next;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      w_low_id;

  assign w_new      = i_en ? (i_halt & i_mask) : '0;
  assign w_vec_next = r_vec | w_new;
  // Unmasked cores count as halted so they never block completion.
  assign o_all_next = &(w_vec_next | ~i_mask);

  // Lowest index among the halts newly sampled on this edge.
  always_comb begin
    w_low_id = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_new[i]) begin
        w_low_id = ID_W'(i);
      end
    end
  end

  // Sticky halt record; first id captured only while the record is still empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec <= '0;
      r_id  <= '0;
    end else if (i_clear) begin
      r_vec <= '0;
      r_id  <= '0;
    end else if (i_en) begin
      r_vec <= w_vec_next;
      if ((r_vec == '0) && (w_new != '0)) begin
        r_id <= w_low_id;
      end
    end
  end

  assign o_halted_vec = r_vec;
  assign o_first_id   = r_id;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: stretches reset into a per-core reset pulse,
// counts run cycles and aggregates sticky core halts into a done flag.
// Optional watchdog enabled by defining RUN_CTRL_WATCHDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 1,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          halt,
  input  logic [NUM_CORES-1:0]          halt_mask,
  input  logic                          restart,
  output logic                          core_rst,
  output logic                          running,
  output logic                          done,
  output logic                          timeout,
  output logic [NUM_CORES-1:0]          halted_vec,
  output logic [id_w(NUM_CORES)-1:0]    first_halt_id,
  output logic [CNT_W-1:0]              cycle_cnt
);

  localparam int unsigned ID_W   = id_w(NUM_CORES);
  localparam int unsigned HOLD_W = id_w(RST_CYCLES);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(RST_CYCLES - 1);

  run_state_t        r_state, w_state_d;
  logic [HOLD_W-1:0] r_hold, w_hold_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d, w_cnt_inc;
  logic              w_clear;
  logic              w_run;
  logic              w_all_next;

  assign w_run     = (r_state == StRun);
  // Saturating increment of the run counter.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  run_ctrl_halt_tracker #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (ID_W)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_run),
    .i_clear      (w_clear),
    .i_halt       (halt),
    .i_mask       (halt_mask),
    .o_halted_vec (halted_vec),
    .o_first_id   (first_halt_id),
    .o_all_next   (w_all_next)
  );

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    w_cnt_d   = r_cnt;
    w_clear   = 1'b0;
    unique case (r_state)
      StHold: begin
        if (r_hold == HoldLast) begin
          w_state_d = StRun;
          w_hold_d  = '0;
        end else begin
          w_hold_d = r_hold + HOLD_W'(1);
        end
      end
      StRun: begin
        w_cnt_d = w_cnt_inc;
        // Completion takes priority over the watchdog on the same edge.
        if (w_all_next) begin
          w_state_d = StDone;
`ifdef RUN_CTRL_WATCHDOG_EN
        end else if (w_cnt_inc >= CNT_W'(TIMEOUT)) begin
          w_state_d = StFault;
`endif
        end
      end
      StDone, StFault: begin
        if (restart) begin
          w_state_d = StHold;
          w_hold_d  = '0;
          w_cnt_d   = '0;
          w_clear   = 1'b1;
        end
      end
      default: begin
        w_state_d = StHold;
        w_hold_d  = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StHold;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_hold  <= w_hold_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    core_rst = (r_state == StHold) || (r_state == StFault);
    running  = (r_state == StRun);
    done     = (r_state == StDone);
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  assign timeout = (r_state == StFault);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign timeout          = 1'b0;
`endif

  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: randomized halt schedules checked against
// an end-of-run prediction computed from halt times and the core mask.
module tb_run_ctrl;

  localparam int unsigned NC = 4;
  localparam int unsigned RC = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 50;
  localparam int          NEVER = 1000;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NC-1:0] halt;
  logic [NC-1:0] halt_mask;
  logic          restart;
  logic          core_rst;
  logic          running;
  logic          done;
  logic          timeout;
  logic [NC-1:0] halted_vec;
  logic [1:0]    first_halt_id;
  logic [CW-1:0] cycle_cnt;

  run_ctrl #(
    .NUM_CORES  (NC),
    .RST_CYCLES (RC),
    .CNT_W      (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .halt_mask     (halt_mask),
    .restart       (restart),
    .core_rst      (core_rst),
    .running       (running),
    .done          (done),
    .timeout       (timeout),
    .halted_vec    (halted_vec),
    .first_halt_id (first_halt_id),
    .cycle_cnt     (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [NC-1:0] vec;
    logic [1:0]    id;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   t_halt[NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Outcome of a run from halt times: the run ends at the latest masked halt,
  // or at the watchdog limit if that comes first.
  function automatic exp_t model(input logic [NC-1:0] m);
    exp_t e;
    int done_at = 1;
    int end_at;
    int best = NEVER + 1;
    for (int i = 0; i < NC; i++) begin
      if (m[i] && t_halt[i] > done_at) done_at = t_halt[i];
    end
    end_at = done_at;
    e.to   = 1'b0;
    if (WD && done_at > TO) begin
      end_at = TO;
      e.to   = 1'b1;
    end
    e.vec = '0;
    e.id  = '0;
    for (int i = 0; i < NC; i++) begin
      if (m[i] && t_halt[i] <= end_at) begin
        e.vec[i] = 1'b1;
        if (t_halt[i] < best) begin
          best = t_halt[i];
          e.id = 2'(i);
        end
      end
    end
    e.cnt = CW'(end_at);
    return e;
  endfunction

  // Monitor: compare on each rising end-of-run indication.
  logic prev_end = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_end = 1'b0;
    end else begin
      if ((done || timeout) && !prev_end) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected_end actual end-of-run required none pending");
        end else begin
          e = sb_q.pop_front();
          check("end_cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
          check("end_halted_vec", 64'(halted_vec), 64'(e.vec));
          check("end_first_id", 64'(first_halt_id), 64'(e.id));
          check("end_timeout", 64'(timeout), 64'(e.to));
          check("end_done", 64'(done), 64'(!e.to));
          check("end_core_rst", 64'(core_rst), 64'(e.to));
        end
      end
      prev_end = done || timeout;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    check({tag, "_running"}, 64'(running), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_timeout"}, 64'(timeout), 64'(0));
    check({tag, "_vec"}, 64'(halted_vec), 64'(0));
    check({tag, "_id"}, 64'(first_halt_id), 64'(0));
    check({tag, "_cnt"}, 64'(cycle_cnt), 64'(0));
  endtask

  // Counts edges from the current point until running is seen.
  task automatic wait_run(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!running && n < 20);
    check({tag, "_hold_edges"}, 64'(n), 64'(RC));
    check({tag, "_core_rst_low"}, 64'(core_rst), 64'(0));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check_reset_outputs("restart");
  endtask

  task automatic async_reset_recover();
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #2 rst = 1'b0;
    halt = '0;
    wait_run("post_rst");
  endtask

  // One run with halt levels rising at t_halt[i]; assumes RUN was just entered.
  task automatic run_scenario(input logic [NC-1:0] m, input bit allow_restart);
    exp_t e;
    int   k = 0;
    bit   ended = 1'b0;
    halt_mask = m;
    e = model(m);
    sb_q.push_back(e);
    while (!ended && k < 200) begin
      k++;
      for (int i = 0; i < NC; i++) halt[i] = (k >= t_halt[i]);
      restart = allow_restart && ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #1;
      ended = done || timeout;
    end
    restart = 1'b0;
    if (!ended) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_end_bound actual no end after %0d edges required done or timeout", k);
      sb_q.delete();
      async_reset_recover();
      return;
    end
    check("run_edges", 64'(k), 64'(e.cnt));
    // Later halts and masked-out cores must not disturb the frozen status.
    repeat (3) begin
      k++;
      for (int i = 0; i < NC; i++) halt[i] = (k >= t_halt[i]);
      @(posedge clk);
      #1;
    end
    check("post_vec", 64'(halted_vec), 64'(e.vec));
    check("post_id", 64'(first_halt_id), 64'(e.id));
    check("post_cnt", 64'(cycle_cnt), 64'(e.cnt));
    check("post_done", 64'(done), 64'(!e.to));
    halt = '0;
    pulse_restart();
    wait_run("rerun");
  endtask

  initial begin
    logic [NC-1:0] m;
    rst       = 1'b1;
    halt      = '0;
    halt_mask = '0;
    restart   = 1'b0;
    #1;
    check_reset_outputs("reset");
    #1 rst = 1'b0;
    wait_run("init");

    // Ordered halts: core 2 first, all done on edge 30.
    t_halt = '{20, 30, 10, 30};
    run_scenario(4'b1111, 1'b1);

    // Masked cores; core 1 halts after done and must be ignored.
    t_halt = '{5, 8, 5, NEVER};
    run_scenario(4'b0101, 1'b0);

    // Empty mask completes after the first run edge.
    t_halt = '{2, 2, 2, 2};
    run_scenario(4'b0000, 1'b0);

    // Final halt on the watchdog-limit edge: completion wins.
    t_halt = '{50, NEVER, NEVER, NEVER};
    run_scenario(4'b0001, 1'b0);

`ifdef RUN_CTRL_WATCHDOG_EN
    // No halts at all: watchdog fault.
    t_halt = '{NEVER, NEVER, NEVER, NEVER};
    run_scenario(4'b1111, 1'b0);
`endif

    // Mid-run asynchronous reset.
    halt_mask = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      halt = (k >= 3) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
    end
    check("midrun_running", 64'(running), 64'(1));
    check("midrun_vec", 64'(halted_vec), 64'(4'b0001));
    check("midrun_cnt", 64'(cycle_cnt), 64'(6));
    async_reset_recover();

    // Randomized schedules.
    for (int s = 0; s < 15; s++) begin
      m = NC'($urandom_range(0, 15));
      for (int i = 0; i < NC; i++) begin
        if (m[i]) t_halt[i] = WD ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
        else      t_halt[i] = int'($urandom_range(1, 80));
      end
      run_scenario(m, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
